// File: rtl/session_ctrl.sv
// Multi-round session sequencer for the reaction-time game.
// Arms core_fsm for ROUNDS trials separated by a GAP_CYCLES idle gap,
// collects the BCD results and keeps last / best / saturating-sum stats.
// Aborts after MAX_MISS false starts. Every output is registered.
// i_rst_n asserts asynchronously; its release is expected to be synchronous
// to i_clk, as produced by the upstream reset generator.
module session_ctrl #(
   parameter int ROUNDS     = 4,
   parameter int GAP_CYCLES = 16,
   parameter int MAX_MISS   = 3
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic        i_cancel,
   input  logic        i_done,
   input  logic        i_miss,
   input  logic [23:0] i_measured,
   output logic        o_arm,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_abort,
   output logic [3:0]  o_round,
   output logic [3:0]  o_misses,
   output logic [23:0] o_last,
   output logic [23:0] o_best,
   output logic [23:0] o_sum
);

   localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
   localparam logic [3:0]    ROUNDS_L = 4'(ROUNDS);
   localparam logic [3:0]    MISS_L   = 4'(MAX_MISS);
   localparam logic [23:0]   BEST_NONE = 24'hFFFFFF;
   localparam logic [23:0]   SUM_SAT   = 24'h999999;

   typedef enum logic [2:0] {S_IDLE, S_GAP, S_ARM, S_WAIT, S_ACC, S_DONE} state_t;

   state_t        r_state, w_state_nxt;
   logic [GW-1:0] r_gap,    w_gap_nxt;
   logic [3:0]    r_round,  w_round_nxt;
   logic [3:0]    r_misses, w_misses_nxt;
   logic [23:0]   r_last,   w_last_nxt;
   logic [23:0]   r_best,   w_best_nxt;
   logic [23:0]   r_sum,    w_sum_nxt;
   logic          r_done,   w_done_nxt;
   logic          r_abort,  w_abort_nxt;
   logic          r_arm,    r_busy;

   // Six cascaded BCD digit adders (sum + last) with +6 correction.
   logic [6:0]  w_carry;
   logic [23:0] w_bcd_sum;
   assign w_carry[0] = 1'b0;
   for (genvar d = 0; d < 6; d++) begin : g_dig
      logic [4:0] w_raw;
      assign w_raw = {1'b0, r_sum[4*d +: 4]} + {1'b0, r_last[4*d +: 4]} + {4'd0, w_carry[d]};
      assign w_carry[d+1] = (w_raw > 5'd9);
      assign w_bcd_sum[4*d +: 4] = w_carry[d+1] ? 4'(w_raw + 5'd6) : w_raw[3:0];
   end

   // Next-state and next-value logic; cancel overrides every other input.
   always_comb begin
      w_state_nxt  = r_state;
      w_gap_nxt    = r_gap;
      w_round_nxt  = r_round;
      w_misses_nxt = r_misses;
      w_last_nxt   = r_last;
      w_best_nxt   = r_best;
      w_sum_nxt    = r_sum;
      w_done_nxt   = r_done;
      w_abort_nxt  = r_abort;
      if (i_cancel) begin
         w_state_nxt = S_IDLE;
         w_done_nxt  = 1'b0;
         w_abort_nxt = 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (i_start) begin
                  w_round_nxt  = '0;
                  w_misses_nxt = '0;
                  w_sum_nxt    = '0;
                  w_last_nxt   = '0;
                  w_best_nxt   = BEST_NONE;
                  w_done_nxt   = 1'b0;
                  w_abort_nxt  = 1'b0;
                  w_gap_nxt    = GAP_LOAD;
                  w_state_nxt  = S_GAP;
               end
            end
            S_GAP: begin
               if (r_gap == '0) w_state_nxt = S_ARM;
               else             w_gap_nxt   = r_gap - 1'b1;
            end
            S_ARM: w_state_nxt = S_WAIT;
            S_WAIT: begin
               // A miss in the same cycle as a result discards the result.
               if (i_miss) begin
                  w_misses_nxt = r_misses + 4'd1;
                  if (w_misses_nxt == MISS_L) begin
                     w_abort_nxt = 1'b1;
                     w_state_nxt = S_DONE;
                  end else begin
                     w_gap_nxt   = GAP_LOAD;
                     w_state_nxt = S_GAP;
                  end
               end else if (i_done) begin
                  w_last_nxt = i_measured;
                  if (i_measured < r_best) w_best_nxt = i_measured;
                  w_state_nxt = S_ACC;
               end
            end
            S_ACC: begin
               w_sum_nxt   = w_carry[6] ? SUM_SAT : w_bcd_sum;
               w_round_nxt = r_round + 4'd1;
               if (w_round_nxt == ROUNDS_L) begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = S_DONE;
               end else begin
                  w_gap_nxt   = GAP_LOAD;
                  w_state_nxt = S_GAP;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Datapath and registered outputs; arm/busy decode the upcoming state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_gap    <= '0;
         r_round  <= '0;
         r_misses <= '0;
         r_last   <= '0;
         r_best   <= BEST_NONE;
         r_sum    <= '0;
         r_done   <= 1'b0;
         r_abort  <= 1'b0;
         r_arm    <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_gap    <= w_gap_nxt;
         r_round  <= w_round_nxt;
         r_misses <= w_misses_nxt;
         r_last   <= w_last_nxt;
         r_best   <= w_best_nxt;
         r_sum    <= w_sum_nxt;
         r_done   <= w_done_nxt;
         r_abort  <= w_abort_nxt;
         r_arm    <= (w_state_nxt == S_ARM);
         r_busy   <= (w_state_nxt inside {S_GAP, S_ARM, S_WAIT, S_ACC});
      end
   end

   assign o_arm    = r_arm;
   assign o_busy   = r_busy;
   assign o_done   = r_done;
   assign o_abort  = r_abort;
   assign o_round  = r_round;
   assign o_misses = r_misses;
   assign o_last   = r_last;
   assign o_best   = r_best;
   assign o_sum    = r_sum;

endmodule

// File: tb/tb_session_ctrl.sv
// Bench for session_ctrl: timeline model with decimal-integer statistics,
// directed scenarios with literal expectations, then random stimulus.
module tb_session_ctrl;

   localparam int ROUNDS = 4;
   localparam int GAP    = 16;
   localparam int MAXM   = 3;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_start = 1'b0, i_cancel = 1'b0, i_done = 1'b0, i_miss = 1'b0;
   logic [23:0] i_measured = '0;
   logic        o_arm, o_busy, o_done, o_abort;
   logic [3:0]  o_round, o_misses;
   logic [23:0] o_last, o_best, o_sum;

   session_ctrl #(.ROUNDS(ROUNDS), .GAP_CYCLES(GAP), .MAX_MISS(MAXM)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_cancel(i_cancel),
      .i_done(i_done), .i_miss(i_miss), .i_measured(i_measured),
      .o_arm(o_arm), .o_busy(o_busy), .o_done(o_done), .o_abort(o_abort),
      .o_round(o_round), .o_misses(o_misses), .o_last(o_last), .o_best(o_best),
      .o_sum(o_sum)
   );

   always #5 i_clk = ~i_clk;

   int n_chk = 0, n_pass = 0, n_arm = 0;

   // Model: session timeline + statistics kept as plain integers.
   bit          m_busy, m_done, m_abort, m_arm, m_wait, m_acc;
   int          m_gap, m_round, m_misses, m_sum;
   logic [23:0] m_last, m_best;

   function automatic int bcd2int(input logic [23:0] b);
      int v = 0;
      for (int k = 5; k >= 0; k--) v = v * 10 + int'(b[4*k +: 4]);
      return v;
   endfunction

   function automatic logic [23:0] int2bcd(input int v);
      logic [23:0] r = '0;
      int x = v;
      for (int k = 0; k < 6; k++) begin
         r[4*k +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_done = 0; m_abort = 0; m_arm = 0; m_wait = 0; m_acc = 0;
      m_gap = 0; m_round = 0; m_misses = 0; m_sum = 0;
      m_last = '0; m_best = 24'hFFFFFF;
   endtask

   // Advance the model across one clock edge using the currently driven inputs.
   task automatic model_edge();
      if (i_cancel) begin
         m_busy = 0; m_arm = 0; m_done = 0; m_abort = 0; m_gap = 0; m_wait = 0; m_acc = 0;
      end else if (!m_busy) begin
         if (i_start) begin
            m_round = 0; m_misses = 0; m_last = '0; m_sum = 0; m_best = 24'hFFFFFF;
            m_done = 0; m_abort = 0; m_busy = 1; m_gap = GAP;
         end
      end else if (m_gap > 0) begin
         m_gap--;
         m_arm = (m_gap == 0);
      end else if (m_arm) begin
         m_arm = 0; m_wait = 1;
      end else if (m_wait) begin
         if (i_miss) begin
            m_misses++; m_wait = 0;
            if (m_misses == MAXM) begin m_busy = 0; m_abort = 1; end
            else m_gap = GAP;
         end else if (i_done) begin
            m_last = i_measured;
            if (i_measured < m_best) m_best = i_measured;
            m_wait = 0; m_acc = 1;
         end
      end else if (m_acc) begin
         m_acc = 0;
         m_sum = m_sum + bcd2int(m_last);
         if (m_sum > 999999) m_sum = 999999;
         m_round++;
         if (m_round == ROUNDS) begin m_busy = 0; m_done = 1; end
         else m_gap = GAP;
      end
   endtask

   task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic check_all();
      chk("arm",    24'(o_arm),    24'(m_arm));
      chk("busy",   24'(o_busy),   24'(m_busy));
      chk("done",   24'(o_done),   24'(m_done));
      chk("abort",  24'(o_abort),  24'(m_abort));
      chk("round",  24'(o_round),  24'(m_round));
      chk("misses", 24'(o_misses), 24'(m_misses));
      chk("last",   o_last,        m_last);
      chk("best",   o_best,        m_best);
      chk("sum",    o_sum,         int2bcd(m_sum));
   endtask

   // One clock: drive inputs, advance model, sample after the edge, compare.
   task automatic step(input logic s, input logic c, input logic d, input logic m,
                       input logic [23:0] meas);
      i_start = s; i_cancel = c; i_done = d; i_miss = m; i_measured = meas;
      model_edge();
      @(posedge i_clk); #1;
      i_start = 0; i_cancel = 0; i_done = 0; i_miss = 0;
      check_all();
      if (o_arm) n_arm++;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, '0);
   endtask

   task automatic wait_arm(output int n);
      n = 0;
      while (!o_arm && n < 100) begin idle(); n++; end
      if (!o_arm) begin
         n_chk++;
         $display("FAIL arm_timeout: no o_arm within %0d cycles", n);
      end
   endtask

   // Wait for arm, enter WAIT, then deliver a result.
   task automatic trial(input logic [23:0] v);
      int n;
      wait_arm(n);
      idle();
      step(0, 0, 1, 0, v);
   endtask

   task automatic trial_miss();
      int n;
      wait_arm(n);
      idle();
      step(0, 0, 0, 1, '0);
   endtask

   function automatic logic [23:0] rand_bcd();
      logic [23:0] r = '0;
      int nd = ($urandom_range(0, 3) == 0) ? 6 : 3;
      for (int k = 0; k < nd; k++) r[4*k +: 4] = 4'($urandom_range(0, 9));
      return r;
   endfunction

   initial begin
      int n;
      logic [23:0] res [4];
      res[0] = 24'h000250; res[1] = 24'h000180; res[2] = 24'h000300; res[3] = 24'h000220;

      model_reset();
      #7;
      check_all();
      chk("rst_best", o_best, 24'hFFFFFF);
      #10 i_rst_n = 1'b1;
      idle(); idle();

      // Normal session.
      n_arm = 0;
      step(1, 0, 0, 0, '0);
      wait_arm(n);
      chk("first_arm_lat", 24'(n + 1), 24'd17);
      idle();
      step(0, 0, 1, 0, res[0]);
      wait_arm(n);
      chk("arm_after_acc", 24'(n), 24'd17);
      idle();
      step(0, 0, 1, 0, res[1]);
      trial(res[2]);
      trial(res[3]);
      chk("round_pre_acc", 24'(o_round), 24'd3);
      idle();
      chk("norm_done",  24'(o_done), 24'd1);
      chk("norm_round", 24'(o_round), 24'd4);
      chk("norm_best",  o_best, 24'h000180);
      chk("norm_last",  o_last, 24'h000220);
      chk("norm_sum",   o_sum,  24'h000950);
      chk("norm_arms",  24'(n_arm), 24'd4);
      idle();

      // Miss handling: miss, done 400, miss, miss.
      n_arm = 0;
      step(1, 0, 0, 0, '0);
      trial_miss();
      trial(24'h000400);
      trial_miss();
      trial_miss();
      idle();
      chk("miss_abort",  24'(o_abort), 24'd1);
      chk("miss_done",   24'(o_done), 24'd0);
      chk("miss_count",  24'(o_misses), 24'd3);
      chk("miss_round",  24'(o_round), 24'd1);
      chk("miss_best",   o_best, 24'h000400);
      chk("miss_arms",   24'(n_arm), 24'd4);

      // Saturation.
      step(1, 0, 0, 0, '0);
      trial(24'h600000);
      trial(24'h500000);
      idle();
      chk("sat_sum2", o_sum, 24'h999999);
      trial(24'h000001);
      idle();
      chk("sat_sum3", o_sum, 24'h999999);
      step(0, 1, 0, 0, '0);

      // Simultaneous done+miss in WAIT.
      step(1, 0, 0, 0, '0);
      trial(24'h000300);
      wait_arm(n);
      idle();
      step(0, 0, 1, 1, 24'h000100);
      chk("sim_misses", 24'(o_misses), 24'd1);
      chk("sim_last",   o_last, 24'h000300);
      chk("sim_best",   o_best, 24'h000300);
      wait_arm(n);
      chk("sim_rearm", 24'(n + 1), 24'(GAP + 1));
      step(0, 1, 0, 0, '0);

      // Cancel in round-2 gap, then restart.
      step(1, 0, 0, 0, '0);
      trial(24'h000123);
      idle(); idle();
      step(0, 1, 0, 0, '0);
      chk("cancel_busy",  24'(o_busy), 24'd0);
      chk("cancel_round", 24'(o_round), 24'd1);
      step(1, 0, 0, 0, '0);
      chk("restart_best", o_best, 24'hFFFFFF);
      wait_arm(n);
      chk("restart_arm_lat", 24'(n + 1), 24'd17);

      // Async reset while in WAIT.
      idle();
      #2 i_rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      chk("arst_round", 24'(o_round), 24'd0);
      chk("arst_best",  o_best, 24'hFFFFFF);
      #3 i_rst_n = 1'b1;
      step(0, 0, 1, 0, 24'h000777);
      chk("arst_no_upd", o_last, 24'h000000);

      // Random stimulus.
      for (int c = 0; c < 4000; c++) begin
         step($urandom_range(0, 19) == 0, $urandom_range(0, 149) == 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 24) == 0, rand_bcd());
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
